ctrl_sequencer: RTL and testbench

Multi-cycle control sequencer that sits directly upstream of the ALU and the data-move/memory path. It owns the PC and fetches 9-bit instructions over a request/valid handshake. It decodes each instruction into a 3-bit arithmetic opcode (ADD=000, LSL=001, XOR=010, AND=011, CMP=100, LSR=101, SET=110, SUB=111) or a 2-bit data opcode (MOVE=00, FLAG=01, LOAD=10, STORE=11), and strobes the downstream stages one operation at a time.

---
 rtl/ctrl_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle fetch/decode/execute control sequencer (optional RETIRE_COUNT_EN retire counter)
module ctrl_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic            inst_req,
    output logic [PC_W-1:0] pc,
    input  logic            inst_valid,
    input  logic [8:0]      inst,
    output logic            alu_en,
    output logic [2:0]      alu_op,
    output logic            data_en,
    output logic [1:0]      data_op,
    output logic [4:0]      operand,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            reg_we,
    input  logic            flag_in,
    output logic            halted,
    output logic            fault
`ifdef RETIRE_COUNT_EN
    ,
    output logic [15:0]     retired
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } seqState_t;

    seqState_t        state;
    seqState_t        stateNext;
    logic [PC_W-1:0]  pcNext;
    logic [8:0]       instReg;
    logic [CNT_W-1:0] memCnt;
    logic             timeoutHit;

    logic             isArith;
    logic             isData;
    logic             isHalt;
    logic             isBranch;
    logic             isMemOp;
    logic             isLoad;
    logic             noWriteback;
    logic [PC_W-1:0]  branchOffset;
    logic             instDone;

    // Instruction classification from the latched instruction word
    always_comb begin
        isArith      = ~instReg[8];
        isData       = (instReg[8:7] == 2'b10);
        isHalt       = (instReg == 9'h1FF);
        isBranch     = (instReg[8:7] == 2'b11) && !isHalt;
        isMemOp      = isData && instReg[6];
        isLoad       = isData && (instReg[6:5] == 2'b10);
        // CMP and FLAG only update condition state, so they skip write-back
        noWriteback  = (isArith && (instReg[7:5] == 3'b100)) ||
                       (isData  && (instReg[6:5] == 2'b01));
        branchOffset = {{(PC_W-7){instReg[6]}}, instReg[6:0]};
    end

    // State register; Reset forces FETCH asynchronously so mem_req drops at once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, next-pc and per-state output strobes
    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        inst_req   = 1'b0;
        alu_en     = 1'b0;
        data_en    = 1'b0;
        mem_req    = 1'b0;
        reg_we     = 1'b0;
        halted     = 1'b0;
        timeoutHit = 1'b0;
        instDone   = 1'b0;
        case (state)
            FETCH: begin
                inst_req = 1'b1;
                if (inst_valid) begin
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                if (isHalt) begin
                    stateNext = HALTED;
                end else if (isBranch) begin
                    pcNext    = flag_in ? (pc + branchOffset) : (pc + PC_W'(1));
                    stateNext = FETCH;
                    instDone  = 1'b1;
                end else if (isMemOp) begin
                    stateNext = MEM;
                end else begin
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                alu_en  = isArith;
                data_en = isData;
                if (noWriteback) begin
                    pcNext    = pc + PC_W'(1);
                    stateNext = FETCH;
                    instDone  = 1'b1;
                end else begin
                    stateNext = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                data_en = (memCnt == '0);
                // A late ack on the final allowed cycle still completes normally
                if (mem_ack) begin
                    if (isLoad) begin
                        stateNext = WB;
                    end else begin
                        pcNext    = pc + PC_W'(1);
                        stateNext = FETCH;
                        instDone  = 1'b1;
                    end
                end else if (memCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    timeoutHit = 1'b1;
                    stateNext  = HALTED;
                end
            end
            WB: begin
                reg_we    = 1'b1;
                pcNext    = pc + PC_W'(1);
                stateNext = FETCH;
                instDone  = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // PC, decoded fields, memory wait counter and sticky fault
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc      <= '0;
            instReg <= '0;
            alu_op  <= '0;
            data_op <= '0;
            operand <= '0;
            memCnt  <= '0;
            fault   <= 1'b0;
        end else begin
            pc <= pcNext;
            if (state == FETCH && inst_valid) begin
                instReg <= inst;
                operand <= inst[4:0];
                if (!inst[8]) begin
                    alu_op <= inst[7:5];
                end else if (!inst[7]) begin
                    data_op <= inst[6:5];
                end
            end
            if (state == MEM) begin
                memCnt <= memCnt + CNT_W'(1);
            end else begin
                memCnt <= '0;
            end
            if (timeoutHit) begin
                fault <= 1'b1;
            end
        end
    end

`ifdef RETIRE_COUNT_EN
    // Saturating count of completed instructions; HALT never completes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retired <= '0;
        end else if (instDone && retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
`timescale 1ns/1ps
module tb_ctrl_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       inst_req;
    logic [7:0] pc;
    logic       inst_valid;
    logic [8:0] inst;
    logic       alu_en;
    logic [2:0] alu_op;
    logic       data_en;
    logic [1:0] data_op;
    logic [4:0] operand;
    logic       mem_req;
    logic       mem_ack;
    logic       reg_we;
    logic       flag_in;
    logic       halted;
    logic       fault;
`ifdef RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    int nChecks = 0;
    int nBad    = 0;

    ctrl_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .inst_req   (inst_req),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .data_en    (data_en),
        .data_op    (data_op),
        .operand    (operand),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .reg_we     (reg_we),
        .flag_in    (flag_in),
        .halted     (halted),
        .fault      (fault)
`ifdef RETIRE_COUNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Present one instruction in FETCH; returns at the DECODE cycle
    task automatic fetch(input logic [8:0] i);
        check("fetch_req", inst_req, 1);
        inst       = i;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        check("decode_req_low", inst_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; inst_valid = 1'b0; inst = '0; mem_ack = 1'b0; flag_in = 1'b0;
        step(); step();
        check("rst_pc", pc, 0);
        check("rst_inst_req", inst_req, 1);
        check("rst_alu_en", alu_en, 0);
        check("rst_data_en", data_en, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_data_op", data_op, 0);
        check("rst_operand", operand, 0);
`ifdef RETIRE_COUNT_EN
        check("rst_retired", retired, 0);
`endif
        Reset = 1'b0;
        step(); step();
        check("stall_pc", pc, 0);
        check("stall_req", inst_req, 1);

        // ADD at pc 0
        fetch(9'h000);
        check("add_dec_alu_en", alu_en, 0);
        step();
        check("add_alu_en", alu_en, 1);
        check("add_alu_op", alu_op, 3'b000);
        check("add_exec_we", reg_we, 0);
        step();
        check("add_wb_we", reg_we, 1);
        check("add_wb_pc", pc, 0);
        step();
        check("add_pc", pc, 1);

        // Taken branch -2 from pc 1 wraps to 0xFF
        fetch(9'h1FE);
        flag_in = 1'b1;
        step();
        flag_in = 1'b0;
        check("br_taken_pc", pc, 8'hFF);
        check("br_taken_req", inst_req, 1);

        // CMP at 0xFF: no write-back, pc+1 wraps to 0
        fetch(9'h080);
        step();
        check("cmp_alu_en", alu_en, 1);
        check("cmp_alu_op", alu_op, 3'b100);
        step();
        check("cmp_no_we", reg_we, 0);
        check("cmp_back_fetch", inst_req, 1);
        check("cmp_pc_wrap", pc, 0);

        // Untaken branch -> pc+1
        fetch(9'h1FE);
        step();
        check("br_untaken_pc", pc, 1);

        // LOAD operand 5, ack in third MEM cycle
        fetch(9'h145);
        check("ld_data_op", data_op, 2'b10);
        check("ld_operand", operand, 5);
        step();
        check("ld_m1_data_en", data_en, 1);
        check("ld_m1_mem_req", mem_req, 1);
        step();
        check("ld_m2_data_en", data_en, 0);
        check("ld_m2_mem_req", mem_req, 1);
        step();
        check("ld_m3_mem_req", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("ld_wb_mem_req", mem_req, 0);
        check("ld_wb_we", reg_we, 1);
        step();
        check("ld_pc", pc, 2);

        // STORE: ack at once, back to FETCH without write-back
        fetch(9'h160);
        step();
        check("st_mem_req", mem_req, 1);
        check("st_data_op", data_op, 2'b11);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("st_back_fetch", inst_req, 1);
        check("st_no_we", reg_we, 0);
        check("st_pc", pc, 3);

        // MOVE operand 10
        fetch(9'h10A);
        step();
        check("mv_data_en", data_en, 1);
        check("mv_alu_en", alu_en, 0);
        check("mv_data_op", data_op, 2'b00);
        check("mv_operand", operand, 10);
        step();
        check("mv_wb_we", reg_we, 1);
        step();
        check("mv_pc", pc, 4);

        // FLAG: no write-back
        fetch(9'h120);
        step();
        check("fl_data_en", data_en, 1);
        check("fl_data_op", data_op, 2'b01);
        step();
        check("fl_back_fetch", inst_req, 1);
        check("fl_no_we", reg_we, 0);
        check("fl_pc", pc, 5);

        // LOAD with ack on the 15th MEM cycle: completes, no fault
        fetch(9'h140);
        step();
        repeat (13) step();
        check("aw_m14_mem_req", mem_req, 1);
        step();
        check("aw_m15_mem_req", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("aw_fault", fault, 0);
        check("aw_halted", halted, 0);
        check("aw_wb_we", reg_we, 1);
        step();
        check("aw_pc", pc, 6);

        // LOAD with no ack: fault after 15 cycles
        fetch(9'h140);
        step();
        repeat (14) step();
        check("to_m15_mem_req", mem_req, 1);
        check("to_m15_fault", fault, 0);
        step();
        check("to_fault", fault, 1);
        check("to_halted", halted, 1);
        check("to_mem_req", mem_req, 0);
        check("to_inst_req", inst_req, 0);
        check("to_pc", pc, 6);
        inst_valid = 1'b1;
        mem_ack    = 1'b1;
        repeat (3) step();
        inst_valid = 1'b0;
        mem_ack    = 1'b0;
        check("hlt_pc_frozen", pc, 6);
        check("hlt_inst_req", inst_req, 0);
        check("hlt_fault_sticky", fault, 1);

        // Reset clears fault; then reset asynchronously mid-MEM
        Reset = 1'b1;
        step();
        check("rst2_fault", fault, 0);
        check("rst2_halted", halted, 0);
        Reset = 1'b0;
        step();
        fetch(9'h000);
        step(); step(); step();
        fetch(9'h15F);
        step();
        step();
        check("mid_mem_req", mem_req, 1);
        check("mid_pc", pc, 1);
        #1 Reset = 1'b1;
        #1;
        check("async_mem_req", mem_req, 0);
        check("async_pc", pc, 0);
        check("async_operand", operand, 0);
        check("async_data_op", data_op, 0);
        check("async_inst_req", inst_req, 1);
        step();
        Reset = 1'b0;
        step();

        // ADD, CMP, STORE, branch, HALT
        fetch(9'h000);
        step(); step(); step();
        fetch(9'h080);
        step(); step();
        fetch(9'h160);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        fetch(9'h1FE);
        step();
        check("seq_pc", pc, 4);
        fetch(9'h1FF);
        check("halt_dec_halted", halted, 0);
        step();
        check("halt_halted", halted, 1);
        check("halt_fault", fault, 0);
        check("halt_inst_req", inst_req, 0);
        check("halt_pc", pc, 4);
`ifdef RETIRE_COUNT_EN
        check("retired", retired, 4);
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
